// File: rtl/vedic_pkg.sv
// Shared constants for the Vedic pipelined multiplier.
// Holds the legal operand widths and the pipeline depth.
// A helper lets the top module reject illegal widths at elaboration.
package vedic_pkg;

  // Depth of the multiply pipeline (operand register stage + result stage).
  localparam int NUM_STAGES = 2;

  // Operand widths the recursive core is built and checked for.
  localparam int NUM_LEGAL_WIDTHS = 3;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{8, 16, 32};

  // True when w appears in the legal width list.
  function automatic bit is_legal_width(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/vedic_core.sv
// Purpose: unsigned W x W Vedic (Urdhva-Tiryagbhyam) multiplier, recursive to a 2x2 base.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the enclosing pipeline registers around it.
module vedic_core #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  generate
    if (W == 2) begin : g_base
      logic c1;

      // 2x2 crosswise/vertical base cell: two half adders on the four bit products.
      always_comb begin
        p[0] = a[0] & b[0];
        p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
        c1   = (a[1] & b[0]) & (a[0] & b[1]);
        p[2] = (a[1] & b[1]) ^ c1;
        p[3] = (a[1] & b[1]) & c1;
      end
    end else begin : g_split
      localparam int H = W / 2;

      logic [W-1:0] pp_ll;
      logic [W-1:0] pp_hl;
      logic [W-1:0] pp_lh;
      logic [W-1:0] pp_hh;
      logic [W:0]   mid;

      vedic_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pp_ll));
      vedic_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(pp_hl));
      vedic_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(pp_lh));
      vedic_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(pp_hh));

      // Recombine the half-width products; the cross terms share one carry bit.
      always_comb begin
        mid = {1'b0, pp_hl} + {1'b0, pp_lh};
        p   = {pp_hh, pp_ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
      end
    end
  endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// Purpose: 2-stage signed/unsigned WIDTH x WIDTH multiplier built from four Vedic half-width cores.
// Latency: 2 cycles from input transfer to out_valid; one result per cycle when unstalled.
// Backpressure: in_ready = !out_valid || out_ready; both stages freeze together when it is low.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     i1,
  input  logic [WIDTH-1:0]     i2,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  if (!is_legal_width(WIDTH)) begin : g_width_check
    $error("vedic_mult_pipe: WIDTH must be one of 8, 16, 32");
  end

  // Pipeline-wide enable: the output slot is free or being drained this cycle.
  logic advance;

  // Stage-1 combinational operand conditioning.
  logic             signed_mode;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             res_neg;
  logic [WIDTH-1:0] pp_ll;
  logic [WIDTH-1:0] pp_hl;
  logic [WIDTH-1:0] pp_lh;
  logic [WIDTH-1:0] pp_hh;

  // Stage-1 registers.
  logic             s1_vld_q, s1_vld_d;
  logic             s1_neg_q, s1_neg_d;
  logic [WIDTH-1:0] pp_ll_q, pp_ll_d;
  logic [WIDTH-1:0] pp_hl_q, pp_hl_d;
  logic [WIDTH-1:0] pp_lh_q, pp_lh_d;
  logic [WIDTH-1:0] pp_hh_q, pp_hh_d;

  // Stage-2 combinational recombination.
  logic [WIDTH:0]   mid;
  logic [PW-1:0]    mag_prod;
  logic [PW-1:0]    signed_prod;

  // Stage-2 registers.
  logic             out_vld_q, out_vld_d;
  logic [PW-1:0]    prod_q, prod_d;

  assign advance   = !out_vld_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_vld_q;
  assign Product   = prod_q;

  // Operand magnitudes and result sign; the most negative value negates to
  // itself, which read as unsigned is exactly its magnitude 2^(WIDTH-1).
  always_comb begin
    signed_mode = (SIGNED_EN != 0) && sgn;
    mag1        = (signed_mode && i1[WIDTH-1]) ? (~i1 + WIDTH'(1)) : i1;
    mag2        = (signed_mode && i2[WIDTH-1]) ? (~i2 + WIDTH'(1)) : i2;
    res_neg     = signed_mode && (i1[WIDTH-1] ^ i2[WIDTH-1]);
  end

  vedic_core #(.W(H)) u_pp_ll (.a(mag1[H-1:0]),     .b(mag2[H-1:0]),     .p(pp_ll));
  vedic_core #(.W(H)) u_pp_hl (.a(mag1[WIDTH-1:H]), .b(mag2[H-1:0]),     .p(pp_hl));
  vedic_core #(.W(H)) u_pp_lh (.a(mag1[H-1:0]),     .b(mag2[WIDTH-1:H]), .p(pp_lh));
  vedic_core #(.W(H)) u_pp_hh (.a(mag1[WIDTH-1:H]), .b(mag2[WIDTH-1:H]), .p(pp_hh));

  // Stage-1 next state: capture partial products on an accepted transfer, bubble otherwise.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_neg_d = s1_neg_q;
    pp_ll_d  = pp_ll_q;
    pp_hl_d  = pp_hl_q;
    pp_lh_d  = pp_lh_q;
    pp_hh_d  = pp_hh_q;
    if (advance) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_neg_d = res_neg;
        pp_ll_d  = pp_ll;
        pp_hl_d  = pp_hl;
        pp_lh_d  = pp_lh;
        pp_hh_d  = pp_hh;
      end
    end
  end

  // Stage-2 recombination and sign fix-up; a zero magnitude stays zero.
  always_comb begin
    mid         = {1'b0, pp_hl_q} + {1'b0, pp_lh_q};
    mag_prod    = {pp_hh_q, pp_ll_q} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
    signed_prod = (s1_neg_q && (mag_prod != '0)) ? (~mag_prod + PW'(1)) : mag_prod;
  end

  // Stage-2 next state: load the result when advancing, otherwise hold it for the consumer.
  always_comb begin
    out_vld_d = out_vld_q;
    prod_d    = prod_q;
    if (advance) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) prod_d = signed_prod;
    end
  end

  // Pipeline registers; reset empties both stages and zeroes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_neg_q  <= 1'b0;
      pp_ll_q   <= '0;
      pp_hl_q   <= '0;
      pp_lh_q   <= '0;
      pp_hh_q   <= '0;
      out_vld_q <= 1'b0;
      prod_q    <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_neg_q  <= s1_neg_d;
      pp_ll_q   <= pp_ll_d;
      pp_hl_q   <= pp_hl_d;
      pp_lh_q   <= pp_lh_d;
      pp_hh_q   <= pp_hh_d;
      out_vld_q <= out_vld_d;
      prod_q    <= prod_d;
    end
  end

endmodule

// File: doc/vedic_mult_pipe.md
VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values 8, 16, 32.
REQ-002 SHALL have parameter SIGNED_EN, default 1; 1 enables the signed mode input, 0 ties signed mode to unsigned.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand pair present.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port i1, input, WIDTH, multiplicand.
REQ-008 SHALL have port i2, input, WIDTH, multiplier.
REQ-009 SHALL have port sgn, input, 1, 1 = two's-complement operands; sampled with i1/i2.
REQ-010 SHALL have port out_valid, output, 1, Product valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts Product.
REQ-012 SHALL have port Product, output, 2*WIDTH, full-width result.

Function
REQ-013 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-014 SHALL implement a 2-stage pipeline; latency SHALL be exactly 2 cycles from input transfer to out_valid with no stall.
REQ-015 SHALL form stage 1 as follows: convert operands to magnitudes when sgn=1, record result sign = MSB(i1) XOR MSB(i2), compute four WIDTH/2 x WIDTH/2 partial products (lo*lo, hi*lo, lo*hi, hi*hi), and register all four with the sign and valid.
REQ-016 SHALL form stage 2 as follows: Product = PP_hh<<WIDTH + (PP_hl+PP_lh)<<(WIDTH/2) + PP_ll, computed at 2*WIDTH bits with no truncation, then two's-complement negated if the sign bit is set; register the result with out_valid.
REQ-017 SHALL treat the most negative operand (-2^(WIDTH-1)) as magnitude 2^(WIDTH-1) in WIDTH unsigned bits; the result SHALL be exact, including for -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-018 SHALL never output negative zero: a zero magnitude product SHALL produce all-zero Product regardless of sign.
REQ-019 SHALL ignore sgn and use unsigned arithmetic when SIGNED_EN=0.
REQ-020 SHALL define advance = !out_valid || out_ready, with in_ready = advance; both pipeline stages SHALL hold when advance=0.
REQ-021 SHALL allow stages to advance when empty (bubbles), accepting one transfer per cycle at full throughput.
REQ-022 SHALL hold Product and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL insert a bubble when in_valid=0 with advance=1; out_valid SHALL fall 2 cycles later if no new data arrives.

Reset
REQ-024 SHALL clear stage valids, out_valid and Product to 0 immediately on rst assertion; in_ready SHALL read 1 during and after reset.
REQ-025 SHALL discard in-flight operands when rst asserts mid-operation; no stale Product SHALL appear after release.
REQ-026 SHALL ignore in_valid while rst is high.

Structure
REQ-027 SHALL place the legal WIDTH list and the stage-count constant (2) in shared package vedic_pkg.
REQ-028 SHALL use one combinational sub-module, vedic_core, parameterised by width, recursive down to a 2x2 base; it SHALL be instantiated four times at WIDTH/2.

Verification
REQ-029 SHALL cover, for WIDTH=16 unsigned: 0xFFFF*0xFFFF -> Product 0xFFFE0001, out_valid exactly 2 cycles after the transfer.
REQ-030 SHALL cover, for WIDTH=16 signed: 0x8000*0x8000 -> 0x40000000; 0xFFFF*0x0003 -> 0xFFFFFFFD; 0x0000*0xFFFF -> 0x00000000.
REQ-031 SHALL cover back-to-back streaming: 100 random pairs, out_ready=1 -> 100 outputs in order, one per cycle, all matching the reference model.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles with a continuous input stream -> in_ready=0 after the pipeline fills, Product held, no loss or duplication.
REQ-033 SHALL cover reset mid-flight: rst pulsed with 2 items in flight -> out_valid=0, Product=0, and only post-reset items are emitted.
REQ-034 SHALL cover WIDTH=8 and WIDTH=32: exhaustive 8-bit signed and unsigned checks; 32-bit 0xFFFFFFFF*0xFFFFFFFF unsigned -> 0xFFFFFFFE00000001.
